ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the MIPS pipeline, alongside the ALU. It takes operand A from the register-file read port (rs) and operand B from the ALUSrc multiplexer output. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle latency and holds the results in architectural HI/LO registers for MFHI/MFLO. The hazard unit uses `busy` to stall dependent HI/LO accesses.

---
 rtl/ex_muldiv.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// One bit per cycle: shift-add multiply or restoring divide on operand
// magnitudes, followed by a sign-fixup cycle that writes HI/LO.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t             state, state_nxt;
  logic               load, step, commit, mt_ok;
  logic               is_div_q, sign_q, sign_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] acc;         // product, or {remainder, dividend/quotient}

  logic               sgn;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]   quo, remf;

  // Magnitude of a two's-complement value; INT_MIN maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] r;
    r = x[WIDTH-1] ? -x : x;
    return r;
  endfunction

  // Conditional two's-complement negation, single width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Conditional two's-complement negation, double width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode; flush always wins over start.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CW'(WIDTH-1)) state_nxt = FIXUP;
        end
      end
      FIXUP: begin
        state_nxt = IDLE;
        commit    = !flush;
      end
      default: state_nxt = IDLE;
    endcase
    mt_ok = (state == IDLE) && !start;
  end

  // Operand conditioning, one iteration step of each algorithm, and fixup values.
  always_comb begin
    sgn     = ~op[0];
    a_abs   = sgn ? mag(src_a) : src_a;
    b_abs   = sgn ? mag(src_b) : src_b;
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_nxt = {msum, acc[WIDTH-1:1]};
    dshift  = acc[2*WIDTH-1:WIDTH-1];
    ddiff   = dshift - {1'b0, opnd_q};
    div_nxt = ddiff[WIDTH] ? {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {ddiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    prod    = neg_2w(acc, sign_q);
    // A zero divisor yields an all-ones quotient regardless of sign.
    quo     = (opnd_q == '0) ? {WIDTH{1'b1}} : neg_w(acc[WIDTH-1:0], sign_q);
    remf    = neg_w(acc[2*WIDTH-1:WIDTH], sign_r);
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      cnt      <= '0;
      opnd_q   <= '0;
      acc      <= '0;
    end else if (load) begin
      is_div_q <= op[1];
      sign_q   <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      sign_r   <= sgn & src_a[WIDTH-1];
      cnt      <= '0;
      opnd_q   <= op[1] ? b_abs : a_abs;
      acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
    end else if (step) begin
      cnt      <= cnt + CW'(1);
      acc      <= is_div_q ? div_nxt : mul_nxt;
    end
  end

  // Architectural HI/LO: operation results or MTHI/MTLO writes while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= is_div_q ? remf : prod[2*WIDTH-1:WIDTH];
      lo <= is_div_q ? quo  : prod[WIDTH-1:0];
    end else if (mt_ok) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // Completion pulse, one cycle after the fixup edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= commit;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv with an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv;

  localparam int W      = 32;
  localparam int DONE_C = W + 2;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          flush  = 1'b0;
  logic          hi_we  = 1'b0;
  logic          lo_we  = 1'b0;
  logic [1:0]    op     = 2'b00;
  logic [W-1:0]  src_a  = '0;
  logic [W-1:0]  src_b  = '0;
  logic [W-1:0]  wdata  = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [63:0]   sb_q[$];
  logic [63:0]   sb_e;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO result from plain integer arithmetic, {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa64, sb64;
    int     sa, sb, q, r;
    logic [63:0] p;
    case (o)
      2'b00: begin
        sa64 = $signed(a);
        sb64 = $signed(b);
        p = sa64 * sb64;
      end
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        sa = a;
        sb = b;
        if (b == 0)                                  p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)      p = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r, q};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'(int'($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 with nothing pending, expected done=0");
      end else begin
        sb_e = sb_q.pop_front();
        chk("result_hi", hi, sb_e[63:32]);
        chk("result_lo", lo, sb_e[31:0]);
        m_hi = sb_e[63:32];
        m_lo = sb_e[31:0];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mt(input bit sel_hi, input logic [W-1:0] d);
    @(posedge clk); #1;
    wdata = d;
    hi_we = sel_hi;
    lo_we = !sel_hi;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (sel_hi) m_hi = d; else m_lo = d;
    @(negedge clk);
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  // Launch one operation in the current cycle (cycle 0) and follow it cycle by cycle.
  // flush_at / inj_at / rst_at < 0 disable the respective disturbance.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input int inj_at, input int rst_at);
    if (flush_at < 0 && rst_at < 0) sb_q.push_back(model(o, a, b));
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    for (int c = 1; c <= DONE_C + 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      hi_we = 1'b0;
      if (c == inj_at) begin
        start = 1'b1;
        op    = 2'b00;
        src_a = $urandom;
        src_b = $urandom;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (c == flush_at) flush = 1'b1;
      if (c == rst_at)   reset = 1'b1;
      @(negedge clk);
      if (c == rst_at) begin
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      if (flush_at >= 0 && c == flush_at + 1) begin
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        break;
      end
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= W + 1));
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == DONE_C));
      if (done || c >= DONE_C) break;
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1, -1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    run_op(2'b11, 32'h1234_5678, 32'd0, -1, -1, -1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, -1, -1, -1);

    mt(1'b1, 32'hAAAA_0000);
    mt(1'b0, 32'h5555_1234);
    run_op(2'b01, 32'd7, 32'd9, 10, -1, -1);
    idle(DONE_C + 4);
    chk("post_flush_hi", hi, 32'hAAAA_0000);
    run_op(2'b01, 32'd7, 32'd9, -1, -1, -1);

    run_op(2'b11, 32'd100, 32'd7, -1, 5, -1);

    run_op(2'b00, $urandom, $urandom, -1, -1, 20);
    idle(DONE_C + 4);
    chk("post_reset_hi", hi, 32'd0);
    chk("post_reset_lo", lo, 32'd0);
    run_op(2'b00, 32'h0001_0000, 32'hFFFF_0000, -1, -1, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, -1, -1, -1);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 5) == 0) mt(1'($urandom_range(0, 1)), $urandom);
    end

    idle(4);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
